// File: rtl/simon_pkg.sv
// Shared types for the Simon Says game sequencer.
package simon_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_WAIT_IN,
    S_CHECK,
    S_GAP,
    S_LOSE,
    S_WIN
  } state_t;

  typedef logic [1:0] led_t;
  typedef logic [3:0] level_t;

endpackage

// File: rtl/simon_game_ctrl_if.sv
// Game controller bundle: key inputs, blinker/memory handshake and status flags.
interface simon_game_ctrl_if;
  import simon_pkg::*;

  logic   start;
  logic   btn_valid;
  led_t   btn_code;
  logic   blink_done;
  led_t   seq_data;
  logic   blink_start;
  level_t level;
  logic   mem_sel;
  level_t seq_addr;
  logic   awaiting_input;
  level_t score;
  logic   game_over;
  logic   game_won;

  modport master (
    input  start, btn_valid, btn_code, blink_done, seq_data,
    output blink_start, level, mem_sel, seq_addr, awaiting_input, score, game_over, game_won
  );

  modport slave (
    output start, btn_valid, btn_code, blink_done, seq_data,
    input  blink_start, level, mem_sel, seq_addr, awaiting_input, score, game_over, game_won
  );

endinterface

// File: rtl/round_timer.sv
// Up-counter shared by the input-timeout and inter-round gap phases.
module round_timer #(
  parameter int W = 28
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count;

  // Terminal cycle is limit-1 so a phase lasts exactly limit cycles; a zero limit expires at once.
  assign expired = (limit == '0) || (count == limit - W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                count <= '0;
    else if (clear)            count <= '0;
    else if (en && !expired)   count <= count + W'(1);
  end

endmodule

// File: rtl/simon_game_ctrl.sv
// Simon Says sequencer: playback, press checking against memory, level/score tracking.
module simon_game_ctrl
  import simon_pkg::*;
#(
  parameter level_t      MAX_LEVEL   = 4'd15,
  parameter logic [27:0] TIMEOUT_CYC = 28'd150_000_000,
  parameter logic [27:0] GAP_CYC     = 28'd25_000_000
) (
  input  logic              clk,
  input  logic              reset,
  simon_game_ctrl_if.master bus
);

  state_t      state;
  led_t        btn_q;
  level_t      level, score, idx;
  logic        blink_start, mem_sel, awaiting_input, game_over, game_won;
  logic        tmr_en, tmr_expired;
  logic [27:0] tmr_limit;

  // Timer idles at zero outside the timed states, so every entry starts from a clean count.
  assign tmr_en    = (state == S_WAIT_IN) || (state == S_GAP);
  assign tmr_limit = (state == S_GAP) ? GAP_CYC : TIMEOUT_CYC;

  round_timer #(.W(28)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!tmr_en),
    .en      (tmr_en),
    .limit   (tmr_limit),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      btn_q          <= '0;
      level          <= 4'd1;
      score          <= '0;
      idx            <= '0;
      blink_start    <= 1'b0;
      mem_sel        <= 1'b0;
      awaiting_input <= 1'b0;
      game_over      <= 1'b0;
      game_won       <= 1'b0;
    end else begin
      blink_start <= 1'b0;
      case (state)
        S_IDLE: if (bus.start) begin
          state       <= S_PLAY;
          blink_start <= 1'b1;
        end
        S_PLAY: if (bus.blink_done) begin
          state          <= S_WAIT_IN;
          idx            <= '0;
          mem_sel        <= 1'b1;
          awaiting_input <= 1'b1;
        end
        // A press on the timeout terminal cycle takes priority.
        S_WAIT_IN: if (bus.btn_valid) begin
          state          <= S_CHECK;
          btn_q          <= bus.btn_code;
          awaiting_input <= 1'b0;
        end else if (tmr_expired) begin
          state          <= S_LOSE;
          awaiting_input <= 1'b0;
          mem_sel        <= 1'b0;
          game_over      <= 1'b1;
        end
        S_CHECK: if (btn_q != bus.seq_data) begin
          state     <= S_LOSE;
          mem_sel   <= 1'b0;
          game_over <= 1'b1;
        end else if (idx < level - 4'd1) begin
          state          <= S_WAIT_IN;
          idx            <= idx + 4'd1;
          awaiting_input <= 1'b1;
        end else begin
          score   <= level;
          mem_sel <= 1'b0;
          if (level >= MAX_LEVEL) begin
            state    <= S_WIN;
            game_won <= 1'b1;
          end else begin
            state <= S_GAP;
            level <= level + 4'd1;
          end
        end
        S_GAP: if (tmr_expired) begin
          state       <= S_PLAY;
          blink_start <= 1'b1;
        end
        S_LOSE, S_WIN: if (bus.start) begin
          state       <= S_PLAY;
          level       <= 4'd1;
          score       <= '0;
          idx         <= '0;
          game_over   <= 1'b0;
          game_won    <= 1'b0;
          blink_start <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.blink_start    = blink_start;
  assign bus.level          = level;
  assign bus.mem_sel        = mem_sel;
  assign bus.seq_addr       = idx;
  assign bus.awaiting_input = awaiting_input;
  assign bus.score          = score;
  assign bus.game_over      = game_over;
  assign bus.game_won       = game_won;

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Scoreboard bench: stimulus queues expected status events, a negedge monitor matches them.
module tb_simon_game_ctrl;

  localparam int GAP = 8;
  localparam int TMO = 20;
  localparam int KPLAY = 0, KWAIT = 1, KLOSE = 2, KWIN = 3;

  typedef struct {
    int kind; int cyc; int lvl; int sc; int addr; int aw; int ov; int won; int ms;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [1:0] mem [16];
  ev_t  q [$];
  logic pa = 1'b0, po = 1'b0, pw = 1'b0;

  simon_game_ctrl_if bus ();

  simon_game_ctrl #(
    .MAX_LEVEL   (4'd3),
    .TIMEOUT_CYC (28'd20),
    .GAP_CYC     (28'd8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.seq_data <= mem[bus.seq_addr];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input int kind, input int c, input int lvl, input int sc, input int addr,
                      input int aw, input int ov, input int won, input int ms);
    ev_t x;
    x.kind = kind; x.cyc = c; x.lvl = lvl; x.sc = sc; x.addr = addr;
    x.aw = aw; x.ov = ov; x.won = won; x.ms = ms;
    q.push_back(x);
  endtask

  task automatic pulse_start(output int e);
    bus.start = 1'b1; tick(); e = cyc; bus.start = 1'b0;
  endtask

  task automatic pulse_done(output int e);
    bus.blink_done = 1'b1; tick(); e = cyc; bus.blink_done = 1'b0;
  endtask

  task automatic press(input logic [1:0] code, output int e);
    bus.btn_valid = 1'b1; bus.btn_code = code; tick(); e = cyc; bus.btn_valid = 1'b0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_level"}, int'(bus.level), 1);
    chk({tag, "_score"}, int'(bus.score), 0);
    chk({tag, "_seq_addr"}, int'(bus.seq_addr), 0);
    chk({tag, "_mem_sel"}, int'(bus.mem_sel), 0);
    chk({tag, "_blink_start"}, int'(bus.blink_start), 0);
    chk({tag, "_awaiting"}, int'(bus.awaiting_input), 0);
    chk({tag, "_game_over"}, int'(bus.game_over), 0);
    chk({tag, "_game_won"}, int'(bus.game_won), 0);
  endtask

  // Monitor: any blink_start pulse or rising status flag is an observable event.
  initial begin
    ev_t a, x;
    bit  hit, ok;
    forever begin
      @(negedge clk);
      hit = 1'b1;
      if (bus.blink_start === 1'b1)                    a.kind = KPLAY;
      else if (bus.awaiting_input === 1'b1 && !pa)     a.kind = KWAIT;
      else if (bus.game_over === 1'b1 && !po)          a.kind = KLOSE;
      else if (bus.game_won === 1'b1 && !pw)           a.kind = KWIN;
      else                                             hit = 1'b0;
      a.cyc = cyc; a.lvl = int'(bus.level); a.sc = int'(bus.score); a.addr = int'(bus.seq_addr);
      a.aw = int'(bus.awaiting_input); a.ov = int'(bus.game_over); a.won = int'(bus.game_won);
      a.ms = int'(bus.mem_sel);
      pa = bus.awaiting_input; po = bus.game_over; pw = bus.game_won;
      if (hit) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got kind=%0d cyc=%0d lvl=%0d sc=%0d, expected no event",
                   a.kind, a.cyc, a.lvl, a.sc);
        end else begin
          x  = q.pop_front();
          ok = (a.kind == x.kind) && (a.cyc == x.cyc) && (a.lvl == x.lvl) && (a.sc == x.sc) &&
               (a.aw == x.aw) && (a.ov == x.ov) && (a.won == x.won);
          if (x.kind == KWAIT && a.addr != x.addr) ok = 1'b0;
          if (x.kind <= KWAIT && a.ms != x.ms)     ok = 1'b0;
          if (!ok) begin
            errors++;
            $display("FAIL event: got kind=%0d cyc=%0d lvl=%0d sc=%0d addr=%0d aw=%0d ov=%0d won=%0d ms=%0d, expected kind=%0d cyc=%0d lvl=%0d sc=%0d addr=%0d aw=%0d ov=%0d won=%0d ms=%0d",
                     a.kind, a.cyc, a.lvl, a.sc, a.addr, a.aw, a.ov, a.won, a.ms,
                     x.kind, x.cyc, x.lvl, x.sc, x.addr, x.aw, x.ov, x.won, x.ms);
          end
        end
      end
    end
  end

  initial begin
    int e, b;
    ev_t x;
    bus.start = 1'b0; bus.btn_valid = 1'b0; bus.btn_code = 2'd0; bus.blink_done = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 2'd0;
    mem[0] = 2'd2; mem[1] = 2'd3; mem[2] = 2'd1;

    repeat (3) tick();
    chk_reset_vals("por");
    reset = 1'b1;
    repeat (2) tick();

    // Level 1, with a press during PLAY and a start during WAIT_IN that must be ignored.
    pulse_start(e);     push(KPLAY, e, 1, 0, 0, 0, 0, 0, 0);
    press(2'd2, e);
    tick();
    pulse_done(e);      push(KWAIT, e, 1, 0, 0, 1, 0, 0, 1);
    pulse_start(e);
    press(2'd2, e);     push(KPLAY, e + 1 + GAP, 2, 1, 0, 0, 0, 0, 0);
    wait_until(e + 1 + GAP); tick();

    // Level 2, with a stray blink_done in WAIT_IN that must not reset the index.
    pulse_done(e);      push(KWAIT, e, 2, 1, 0, 1, 0, 0, 1);
    press(2'd2, e);     push(KWAIT, e + 1, 2, 1, 1, 1, 0, 0, 1);
    tick();
    pulse_done(e);
    press(2'd3, e);     push(KPLAY, e + 1 + GAP, 3, 2, 0, 0, 0, 0, 0);
    wait_until(e + 1 + GAP); tick();

    // Level 3 is MAX_LEVEL: completing it wins.
    pulse_done(e);      push(KWAIT, e, 3, 2, 0, 1, 0, 0, 1);
    press(2'd2, e);     push(KWAIT, e + 1, 3, 2, 1, 1, 0, 0, 1);
    tick();
    press(2'd3, e);     push(KWAIT, e + 1, 3, 2, 2, 1, 0, 0, 1);
    tick();
    press(2'd1, e);     push(KWIN, e + 1, 3, 3, 0, 0, 0, 1, 0);
    repeat (3) tick();

    // Restart from WIN, then a wrong press at level 2.
    mem[0] = 2'd1; mem[1] = 2'd3;
    pulse_start(e);     push(KPLAY, e, 1, 0, 0, 0, 0, 0, 0);
    tick();
    pulse_done(e);      push(KWAIT, e, 1, 0, 0, 1, 0, 0, 1);
    press(2'd1, e);     push(KPLAY, e + 1 + GAP, 2, 1, 0, 0, 0, 0, 0);
    wait_until(e + 1 + GAP); tick();
    pulse_done(e);      push(KWAIT, e, 2, 1, 0, 1, 0, 0, 1);
    press(2'd1, e);     push(KWAIT, e + 1, 2, 1, 1, 1, 0, 0, 1);
    tick();
    press(2'd0, e);     push(KLOSE, e + 1, 2, 1, 0, 0, 1, 0, 0);
    repeat (3) tick();

    // Timeout: no press loses exactly TMO cycles after WAIT_IN entry.
    pulse_start(e);     push(KPLAY, e, 1, 0, 0, 0, 0, 0, 0);
    tick();
    pulse_done(b);      push(KWAIT, b, 1, 0, 0, 1, 0, 0, 1);
                        push(KLOSE, b + TMO, 1, 0, 0, 0, 1, 0, 0);
    wait_until(b + TMO + 2);

    // Press on the terminal timeout cycle wins over the timeout.
    pulse_start(e);     push(KPLAY, e, 1, 0, 0, 0, 0, 0, 0);
    tick();
    pulse_done(b);      push(KWAIT, b, 1, 0, 0, 1, 0, 0, 1);
    wait_until(b + TMO - 1);
    press(2'd1, e);     push(KPLAY, b + TMO + 1 + GAP, 2, 1, 0, 0, 0, 0, 0);
    wait_until(b + TMO + 1 + GAP); tick();

    // Asynchronous reset in the middle of WAIT_IN.
    pulse_done(e);      push(KWAIT, e, 2, 1, 0, 1, 0, 0, 1);
    repeat (2) tick();
    #1 reset = 1'b0;
    #1 chk_reset_vals("mid_wait_reset");
    tick();
    reset = 1'b1;
    tick();

    // Reset squashes a blink_start pulse in the cycle it appears.
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("blink_start_before_reset", int'(bus.blink_start), 1);
    #1 reset = 1'b0;
    #1 chk("blink_start_squashed", int'(bus.blink_start), 0);
    tick();
    reset = 1'b1;
    tick();

    // Back in IDLE, start is honoured.
    pulse_start(e);     push(KPLAY, e, 1, 0, 0, 0, 0, 0, 0);
    repeat (5) tick();

    while (q.size() != 0) begin
      x = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event: got none, expected kind=%0d cyc=%0d", x.kind, x.cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
